binary_census_packer: RTL and testbench

- Consumes the grey-pixel stream and its aligned local average from the local-average filter.
- Binarises each pixel against the average: bit = 1 when pixel > average + THRESH.
- Packs the bits MSB-first into WORD_BITS-wide words tagged with start-of-frame (SOF).
- Buffers words in a small show-ahead FIFO with a valid/ready output, feeding the block-matching line store.

---
 rtl/binary_census_packer_pkg.sv | 14 +
 rtl/sync_fifo_fwft.sv | 59 +++++
 rtl/binary_census_packer.sv | 121 ++++++++++++
 tb/tb_binary_census_packer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/binary_census_packer_pkg.sv
// Shared definitions for the census packer: pixel field layout and the binarising compare.
package binary_census_packer_pkg;

    localparam int unsigned SOF_BIT   = 8;
    localparam int unsigned GREY_BITS = 8;

    typedef logic [GREY_BITS-1:0] grey_t;

    // Compare in 9 bits so avg + thresh never wraps; avg 255 with thresh 0 yields 0.
    function automatic logic binarise(grey_t pix, grey_t avg, grey_t thresh);
        return {1'b0, pix} > ({1'b0, avg} + {1'b0, thresh});
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead FIFO: rd_data always presents the head entry and holds the last popped word when empty.
module sync_fifo_fwft #(
    parameter int unsigned Width = 17,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [Width-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [Width-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   level_q;
    logic [Width-1:0] last_q;
    logic             do_wr, do_rd;

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == (AddrW+1)'(Depth));
        do_rd = rd_en & ~empty;
        // A full FIFO still takes a write when the head leaves on the same edge.
        do_wr = wr_en & (~full | do_rd);
        level = level_q;
        rd_data = empty ? last_q : mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
                last_q   <= mem[rd_ptr_q];
            end
            level_q <= level_q + (AddrW+1)'(do_wr) - (AddrW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/binary_census_packer.sv
// Binarises pixels against their local average and packs the bits MSB-first into SOF-tagged words.
module binary_census_packer
    import binary_census_packer_pkg::*;
#(
    parameter int unsigned WORD_BITS  = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned THRESH     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [8:0]                    pixel,
    input  logic                          pixel_valid,
    input  logic [7:0]                    local_average,
    input  logic                          local_average_valid,
    output logic [WORD_BITS:0]            out_word,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          sync_error
);

    typedef struct packed {
        logic                 sof;
        logic [WORD_BITS-1:0] bits;
    } packed_word_t;

    localparam int unsigned          CountW = $clog2(WORD_BITS) + 1;
    localparam grey_t                ThreshG = grey_t'(THRESH);
    localparam logic [WORD_BITS-1:0] Msb = {1'b1, {(WORD_BITS-1){1'b0}}};

    logic [CountW-1:0]    count_q, count_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 tag_q, tag_d;
    logic                 overflow_q, sync_error_q;

    logic                 accept, mismatch, pix_bit, sof_in;
    logic                 wr_en;
    packed_word_t         wr_word;
    logic                 fifo_full, fifo_empty, fifo_read;

    always_comb begin
        accept   = pixel_valid & local_average_valid;
        mismatch = pixel_valid ^ local_average_valid;
        sof_in   = pixel[SOF_BIT];
        pix_bit  = binarise(pixel[GREY_BITS-1:0], local_average, ThreshG);

        count_d = count_q;
        shift_d = shift_q;
        tag_d   = tag_q;
        wr_en   = 1'b0;
        wr_word = '0;

        if (accept) begin
            if (sof_in && count_q != '0) begin
                // Flush the partial word (low bits already zero) and open a new one.
                wr_en   = 1'b1;
                wr_word = '{sof: tag_q, bits: shift_q};
                tag_d   = 1'b1;
                shift_d = pix_bit ? Msb : '0;
                count_d = CountW'(1);
            end else begin
                if (count_q == '0) begin
                    tag_d = sof_in;
                end
                if (pix_bit) begin
                    shift_d = shift_q | (Msb >> count_q);
                end
                count_d = count_q + CountW'(1);
                if (count_d == CountW'(WORD_BITS)) begin
                    wr_en   = 1'b1;
                    wr_word = '{sof: tag_d, bits: shift_d};
                    count_d = '0;
                    shift_d = '0;
                end
            end
        end
    end

    assign fifo_read = out_ready & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            shift_q      <= '0;
            tag_q        <= 1'b0;
            overflow_q   <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
            tag_q   <= tag_d;
            if (wr_en && fifo_full && !fifo_read) begin
                overflow_q <= 1'b1;
            end
            if (mismatch) begin
                sync_error_q <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .Width (WORD_BITS + 1),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_word),
        .full    (fifo_full),
        .rd_en   (out_ready),
        .rd_data (out_word),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_valid  = ~fifo_empty;
    assign overflow   = overflow_q;
    assign sync_error = sync_error_q;

endmodule

// File: tb/tb_binary_census_packer.sv
// Directed and random checks of the census packer against a queue-based reference model.
module tb_binary_census_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [8:0]  pixel = '0;
    logic        pixel_valid = 1'b0;
    logic [7:0]  local_average = '0;
    logic        local_average_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic [16:0] out_word, out_word_t;
    logic        out_valid, out_valid_t;
    logic [3:0]  fifo_level, fifo_level_t;
    logic        overflow, overflow_t;
    logic        sync_error, sync_error_t;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    binary_census_packer #(.WORD_BITS(16), .FIFO_DEPTH(8), .THRESH(0)) dut (
        .clk                 (clk),
        .reset               (reset),
        .pixel               (pixel),
        .pixel_valid         (pixel_valid),
        .local_average       (local_average),
        .local_average_valid (local_average_valid),
        .out_word            (out_word),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .fifo_level          (fifo_level),
        .overflow            (overflow),
        .sync_error          (sync_error)
    );

    binary_census_packer #(.WORD_BITS(16), .FIFO_DEPTH(8), .THRESH(10)) dut_t (
        .clk                 (clk),
        .reset               (reset),
        .pixel               (pixel),
        .pixel_valid         (pixel_valid),
        .local_average       (local_average),
        .local_average_valid (local_average_valid),
        .out_word            (out_word_t),
        .out_valid           (out_valid_t),
        .out_ready           (out_ready),
        .fifo_level          (fifo_level_t),
        .overflow            (overflow_t),
        .sync_error          (sync_error_t)
    );

    // Reference model (THRESH 0 instance): bit list per word, FIFO as a bounded queue.
    logic [16:0] mq[$];
    logic [16:0] m_last;
    int          m_cnt;
    logic [15:0] m_bits;
    logic        m_tag, m_ovf, m_sync;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_last = '0;
        m_cnt  = 0;
        m_bits = '0;
        m_tag  = 1'b0;
        m_ovf  = 1'b0;
        m_sync = 1'b0;
    endtask

    task automatic model_update(input bit pv, input bit av, input bit sof, input int pix,
                                input int avg, input bit rdy);
        bit          rd, wr, b;
        logic [16:0] w;
        rd = (mq.size() > 0) && rdy;
        wr = 1'b0;
        w  = '0;
        if (pv && av) begin
            b = (pix > avg + 0);
            if (sof && m_cnt > 0) begin
                wr = 1'b1;
                w  = {m_tag, m_bits};
                m_cnt  = 0;
                m_bits = '0;
            end
            if (m_cnt == 0) m_tag = sof;
            if (b) m_bits = m_bits | (16'h1 << (15 - m_cnt));
            m_cnt++;
            if (m_cnt == 16) begin
                wr = 1'b1;
                w  = {m_tag, m_bits};
                m_cnt  = 0;
                m_bits = '0;
            end
        end else if (pv != av) begin
            m_sync = 1'b1;
        end
        if (rd) m_last = mq.pop_front();
        if (wr) begin
            if (mq.size() < 8) mq.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("out_word", 32'(out_word), 32'((mq.size() != 0) ? mq[0] : m_last));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("sync_error", 32'(sync_error), 32'(m_sync));
    endtask

    task automatic step(input bit pv, input bit av, input bit sof, input int pix, input int avg,
                        input bit rdy);
        pixel               = {sof, 8'(pix)};
        pixel_valid         = pv;
        local_average       = 8'(avg);
        local_average_valid = av;
        out_ready           = rdy;
        model_update(pv, av, sof, pix, avg, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        pixel_valid         = 1'b0;
        local_average_valid = 1'b0;
        out_ready           = 1'b0;
        pixel               = '0;
        local_average       = '0;
        reset               = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check_outputs();
        chk("reset_level_t", 32'(fifo_level_t), 32'd0);
        chk("reset_valid_t", 32'(out_valid_t), 32'd0);
    endtask

    initial begin
        int drained;
        int bp[6];
        int ba[6];
        int r;
        bp = '{100, 101, 110, 111, 255, 0};
        ba = '{100, 100, 100, 100, 255, 255};

        // Reset and first word: alternating 200/50 vs 100, SOF on the first pixel.
        do_reset();
        chk("reset_word", 32'(out_word), 32'd0);
        for (int i = 0; i < 16; i++) step(1, 1, i == 0, (i % 2 == 0) ? 200 : 50, 100, 0);
        chk("first_word", 32'(out_word), 32'h1AAAA);
        chk("first_valid", 32'(out_valid), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        chk("empty_holds_last", 32'(out_word), 32'h1AAAA);

        // SOF flush of a 5-bit partial word.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 255, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        chk("flush_word", 32'(out_word), 32'h0F800);
        for (int i = 0; i < 15; i++) step(1, 1, 0, $urandom_range(0, 255), $urandom_range(0, 255), 0);
        step(0, 0, 0, 0, 0, 1);
        chk("post_flush_tag_msb", 32'(out_word[16:15]), 32'h2);
        step(0, 0, 0, 0, 0, 1);

        // Compare boundaries, both THRESH 0 and THRESH 10.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 1, i == 0, bp[i], ba[i], 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 111, 100, 0);
        chk("thresh0_word", 32'(out_word), 32'h173FF);
        chk("thresh10_word", 32'(out_word_t), 32'h113FF);

        // Backpressure: nine words into eight slots, then drain.
        do_reset();
        for (int i = 0; i < 9 * 16; i++)
            step(1, 1, 0, $urandom_range(0, 255), $urandom_range(0, 255), 0);
        chk("bp_level", 32'(fifo_level), 32'd8);
        chk("bp_overflow", 32'(overflow), 32'd1);
        drained = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) drained++;
            step(0, 0, 0, 0, 0, 1);
        end
        chk("bp_drained", 32'(drained), 32'd8);
        chk("bp_overflow_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a read on the completing edge.
        do_reset();
        for (int i = 0; i < 8 * 16 + 15; i++)
            step(1, 1, 0, $urandom_range(0, 255), $urandom_range(0, 255), 0);
        chk("full_level", 32'(fifo_level), 32'd8);
        step(1, 1, 0, 200, 10, 1);
        chk("full_rw_level", 32'(fifo_level), 32'd8);
        chk("full_rw_overflow", 32'(overflow), 32'd0);

        // Valid mismatch and reset mid-word.
        do_reset();
        step(1, 0, 0, 200, 0, 0);
        chk("sync_error_set", 32'(sync_error), 32'd1);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 200, 0, 0);
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        chk("sync_error_av_only", 32'(sync_error), 32'd1);
        for (int i = 0; i < 15; i++) step(1, 1, 0, 200, 0, 0);
        chk("clean_partial", 32'(fifo_level), 32'd0);
        step(1, 1, 0, 200, 0, 0);
        chk("clean_word", 32'(out_word), 32'h0FFFF);

        // Random soak.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            step(r < 8 || r == 8, r < 8 || r == 9, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
